// File: rtl/rr_task_scheduler.sv
// rtl/rr_task_scheduler.sv - priority scheduler with round-robin among equal priorities and a tick-based time slice
module rr_task_scheduler #(
    parameter int NUM_TASKS   = 16,
    parameter int ID_W        = 8,
    parameter int PRIO_W      = 6,
    parameter int ADDR_W      = 32,
    parameter int SLICE_TICKS = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        tick_in,
    input  logic [NUM_TASKS-1:0]        ready_in,
    input  logic [NUM_TASKS*PRIO_W-1:0] prio_in,
    input  logic                        yield_in,
    output logic [ID_W-1:0]             tcb_rd_id_out,
    input  logic [ADDR_W-1:0]           tcb_rd_data_in,
    output logic                        tick_out,
    output logic [ID_W-1:0]             idtask_out,
    output logic [ADDR_W-1:0]           addrtcb_out,
    output logic                        ctx_switch_out,
    output logic                        idle_out,
    output logic                        busy_out
);
    localparam int IDX_W = $clog2(NUM_TASKS);
    localparam logic [ID_W-1:0] IDLE_ID      = '1;
    localparam logic [7:0]      SLICE_RELOAD = 8'(SLICE_TICKS);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_COMMIT, S_COMMIT_IDLE} state_t;

    state_t                      state_q, state_d;
    logic                        tick_r_q, tick_r_d, tick_p_q, tick_p_d;
    logic                        tick_out_q, tick_out_d;
    logic [7:0]                  slice_q, slice_d;
    logic                        pending_q, pending_d;
    logic [NUM_TASKS-1:0]        ready_prev_q, ready_prev_d;
    logic [NUM_TASKS*PRIO_W-1:0] prio_prev_q, prio_prev_d;
    logic [IDX_W-1:0]            scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]            scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]            best_q, best_d;
    logic [PRIO_W-1:0]           best_prio_q, best_prio_d;
    logic                        found_q, found_d;
    logic [ID_W-1:0]             tcb_rd_id_q, tcb_rd_id_d;
    logic [ID_W-1:0]             idtask_q, idtask_d;
    logic [ADDR_W-1:0]           addrtcb_q, addrtcb_d;
    logic                        ctx_q, ctx_d;
    logic                        idle_q, idle_d;

    logic                        tick_edge, expire, pending_set, take;
    logic                        slot_ready;
    logic [PRIO_W-1:0]           slot_prio;

    assign tick_edge  = tick_r_q & ~tick_p_q;
    assign slot_ready = ready_in[scan_idx_q];
    assign slot_prio  = prio_in[32'(scan_idx_q)*PRIO_W +: PRIO_W];

    always_comb begin
        state_d      = state_q;
        tick_r_d     = tick_in;
        tick_p_d     = tick_r_q;
        tick_out_d   = tick_edge;
        slice_d      = slice_q;
        ready_prev_d = ready_in;
        prio_prev_d  = prio_in;
        scan_idx_d   = scan_idx_q;
        scan_cnt_d   = scan_cnt_q;
        best_d       = best_q;
        best_prio_d  = best_prio_q;
        found_d      = found_q;
        tcb_rd_id_d  = tcb_rd_id_q;
        idtask_d     = idtask_q;
        addrtcb_d    = addrtcb_q;
        ctx_d        = 1'b0;
        idle_d       = idle_q;
        expire       = 1'b0;
        take         = 1'b0;

        // The slice only runs while a task owns the CPU; idle holds it full.
        if (tick_edge && !idle_q) begin
            if (slice_q <= 8'd1) begin
                slice_d = SLICE_RELOAD;
                expire  = 1'b1;
            end else begin
                slice_d = slice_q - 8'd1;
            end
        end

        pending_set = expire | yield_in | (ready_in != ready_prev_q) | (prio_in != prio_prev_q);
        pending_d   = pending_q | pending_set;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pending_d   = pending_set;
                    scan_idx_d  = idle_q ? '0 : idtask_q[IDX_W-1:0] + IDX_W'(1);
                    scan_cnt_d  = '0;
                    best_d      = '0;
                    best_prio_d = '0;
                    found_d     = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strictly-greater keeps the earliest slot after the current task on ties.
                take = slot_ready && (!found_q || (slot_prio > best_prio_q));
                if (take) begin
                    best_d      = scan_idx_q;
                    best_prio_d = slot_prio;
                    found_d     = 1'b1;
                end
                scan_idx_d = scan_idx_q + IDX_W'(1);
                scan_cnt_d = scan_cnt_q + IDX_W'(1);
                if (&scan_cnt_q) begin
                    if (found_d) begin
                        tcb_rd_id_d = ID_W'(best_d);
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_COMMIT_IDLE;
                    end
                end
            end
            S_FETCH: state_d = S_COMMIT;
            S_COMMIT: begin
                addrtcb_d = tcb_rd_data_in;
                idtask_d  = ID_W'(best_q);
                idle_d    = 1'b0;
                ctx_d     = (idtask_q != ID_W'(best_q));
                slice_d   = SLICE_RELOAD;
                state_d   = S_IDLE;
            end
            S_COMMIT_IDLE: begin
                addrtcb_d = '0;
                idtask_d  = IDLE_ID;
                idle_d    = 1'b1;
                ctx_d     = !idle_q;
                slice_d   = SLICE_RELOAD;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            tick_r_q     <= 1'b0;
            tick_p_q     <= 1'b0;
            tick_out_q   <= 1'b0;
            slice_q      <= SLICE_RELOAD;
            pending_q    <= 1'b0;
            // Track the inputs through reset so leaving reset is not seen as a change.
            ready_prev_q <= ready_in;
            prio_prev_q  <= prio_in;
            scan_idx_q   <= '0;
            scan_cnt_q   <= '0;
            best_q       <= '0;
            best_prio_q  <= '0;
            found_q      <= 1'b0;
            tcb_rd_id_q  <= '0;
            idtask_q     <= IDLE_ID;
            addrtcb_q    <= '0;
            ctx_q        <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            tick_r_q     <= tick_r_d;
            tick_p_q     <= tick_p_d;
            tick_out_q   <= tick_out_d;
            slice_q      <= slice_d;
            pending_q    <= pending_d;
            ready_prev_q <= ready_prev_d;
            prio_prev_q  <= prio_prev_d;
            scan_idx_q   <= scan_idx_d;
            scan_cnt_q   <= scan_cnt_d;
            best_q       <= best_d;
            best_prio_q  <= best_prio_d;
            found_q      <= found_d;
            tcb_rd_id_q  <= tcb_rd_id_d;
            idtask_q     <= idtask_d;
            addrtcb_q    <= addrtcb_d;
            ctx_q        <= ctx_d;
            idle_q       <= idle_d;
        end
    end

    assign tcb_rd_id_out  = tcb_rd_id_q;
    assign tick_out       = tick_out_q;
    assign idtask_out     = idtask_q;
    assign addrtcb_out    = addrtcb_q;
    assign ctx_switch_out = ctx_q;
    assign idle_out       = idle_q;
    assign busy_out       = (state_q != S_IDLE);
endmodule

// File: tb/tb_rr_task_scheduler.sv
// tb/tb_rr_task_scheduler.sv - self-checking bench for rr_task_scheduler
module tb_rr_task_scheduler;
    localparam int N = 16, ID_W = 8, PRIO_W = 6, ADDR_W = 32, SLICE = 4;

    logic                  aclk = 1'b0;
    logic                  areset, tick_in, yield_in;
    logic [N-1:0]          ready_in;
    logic [N*PRIO_W-1:0]   prio_in;
    logic [ID_W-1:0]       tcb_rd_id_out, idtask_out;
    logic [ADDR_W-1:0]     tcb_rd_data_in, addrtcb_out;
    logic                  tick_out, ctx_switch_out, idle_out, busy_out;

    int tests_run = 0, tests_failed = 0;
    int ctx_cnt = 0, tick_cnt = 0, busy_cnt = 0;
    int cur_id = 255;

    always #5 aclk = ~aclk;

    rr_task_scheduler #(.NUM_TASKS(N), .ID_W(ID_W), .PRIO_W(PRIO_W), .ADDR_W(ADDR_W), .SLICE_TICKS(SLICE)) dut (
        .aclk(aclk), .areset(areset), .tick_in(tick_in), .ready_in(ready_in), .prio_in(prio_in),
        .yield_in(yield_in), .tcb_rd_id_out(tcb_rd_id_out), .tcb_rd_data_in(tcb_rd_data_in),
        .tick_out(tick_out), .idtask_out(idtask_out), .addrtcb_out(addrtcb_out),
        .ctx_switch_out(ctx_switch_out), .idle_out(idle_out), .busy_out(busy_out)
    );

    function automatic logic [31:0] tcb_addr(input logic [7:0] id);
        return 32'h01234567 + {24'd0, id} * 32'h00100010;
    endfunction

    always @(posedge aclk) tcb_rd_data_in <= tcb_addr(tcb_rd_id_out);

    always @(negedge aclk) begin
        if (ctx_switch_out) ctx_cnt++;
        if (tick_out) tick_cnt++;
        if (busy_out) busy_cnt++;
    end

    // Highest ready priority; ties go to the task nearest after the current one in rotation.
    function automatic int model_pick(input int cur, input logic [N-1:0] rdy, input logic [N*PRIO_W-1:0] pr);
        int top = -1, best = 255, best_dist = N + 1, start, d;
        for (int i = 0; i < N; i++)
            if (rdy[i] && int'(pr[i*PRIO_W +: PRIO_W]) > top) top = int'(pr[i*PRIO_W +: PRIO_W]);
        if (top < 0) return 255;
        start = (cur == 255) ? 0 : (cur + 1) % N;
        for (int i = 0; i < N; i++) begin
            d = (i - start + N) % N;
            if (rdy[i] && int'(pr[i*PRIO_W +: PRIO_W]) == top && d < best_dist) begin
                best = i;
                best_dist = d;
            end
        end
        return best;
    endfunction

    function automatic logic [31:0] exp_addr(input int id);
        return (id == 255) ? 32'd0 : tcb_addr(8'(id));
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge aclk);
            #1;
        end
    endtask

    task automatic set_prio(input int i, input int p);
        prio_in[i*PRIO_W +: PRIO_W] = 6'(p);
    endtask

    task automatic do_tick(input int gap);
        tick_in = 1'b1;
        step(2);
        tick_in = 1'b0;
        step(gap);
    endtask

    task automatic test_reset;
        areset = 1'b1;
        step(3);
        tests_run++; if (idle_out !== 1'b1) begin tests_failed++; $display("FAIL reset_idle got %b want 1", idle_out); end
        tests_run++; if (idtask_out !== 8'hFF) begin tests_failed++; $display("FAIL reset_id got %h want ff", idtask_out); end
        tests_run++; if (busy_out !== 1'b0 || ctx_switch_out !== 1'b0 || tick_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses got busy=%b ctx=%b tick=%b want 000", busy_out, ctx_switch_out, tick_out); end
        tests_run++; if (addrtcb_out !== 32'd0 || tcb_rd_id_out !== 8'd0) begin
            tests_failed++; $display("FAIL reset_addr got addr=%h rdid=%h want 0 0", addrtcb_out, tcb_rd_id_out); end
        areset = 1'b0;
        step(1);
    endtask

    task automatic test_idle_ticks;
        int t0 = tick_cnt, b0 = busy_cnt;
        for (int k = 0; k < 10; k++) do_tick(8);
        tests_run++; if (tick_cnt - t0 != 10) begin tests_failed++; $display("FAIL idle_tick_count got %0d want 10", tick_cnt - t0); end
        tests_run++; if (busy_cnt - b0 != 0) begin tests_failed++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_cnt - b0); end
        tests_run++; if (idle_out !== 1'b1 || idtask_out !== 8'hFF) begin
            tests_failed++; $display("FAIL idle_state got idle=%b id=%h want 1 ff", idle_out, idtask_out); end
    endtask

    task automatic test_single;
        int c0 = ctx_cnt;
        set_prio(0, 2);
        ready_in = 16'h0001;
        step(19);
        tests_run++; if (idtask_out !== 8'hFF) begin tests_failed++; $display("FAIL single_early got %h want ff", idtask_out); end
        step(1);
        tests_run++; if (idtask_out !== 8'd0 || addrtcb_out !== 32'h01234567 || idle_out !== 1'b0) begin
            tests_failed++; $display("FAIL single_commit got id=%h addr=%h idle=%b want 00 01234567 0", idtask_out, addrtcb_out, idle_out); end
        step(3);
        tests_run++; if (ctx_cnt - c0 != 1) begin tests_failed++; $display("FAIL single_ctx got %0d pulses want 1", ctx_cnt - c0); end
        cur_id = 0;
    endtask

    task automatic test_round_robin;
        int exp, b0;
        set_prio(1, 'h2A);
        set_prio(2, 'h2A);
        ready_in = 16'h0007;
        exp = model_pick(cur_id, ready_in, prio_in);
        step(20);
        tests_run++; if (idtask_out !== 8'(exp)) begin tests_failed++; $display("FAIL rr_first got %h want %h", idtask_out, 8'(exp)); end
        cur_id = exp;
        for (int k = 0; k < 3; k++) begin
            b0 = busy_cnt;
            repeat (3) do_tick(28);
            tests_run++; if (busy_cnt - b0 != 0) begin tests_failed++; $display("FAIL rr_early_switch got %0d busy cycles want 0", busy_cnt - b0); end
            do_tick(28);
            exp = model_pick(cur_id, ready_in, prio_in);
            tests_run++; if (idtask_out !== 8'(exp) || idtask_out === 8'd0) begin
                tests_failed++; $display("FAIL rr_rotate got %h want %h", idtask_out, 8'(exp)); end
            cur_id = exp;
        end
    endtask

    task automatic test_preempt;
        int c0;
        prio_in = '0;
        set_prio(1, 5);
        ready_in = 16'h0002;
        step(20);
        tests_run++; if (idtask_out !== 8'd1) begin tests_failed++; $display("FAIL preempt_setup got %h want 01", idtask_out); end
        cur_id = 1;
        c0 = ctx_cnt;
        set_prio(3, 9);
        ready_in = 16'h000A;
        step(19);
        tests_run++; if (idtask_out !== 8'd1) begin tests_failed++; $display("FAIL preempt_early got %h want 01", idtask_out); end
        step(1);
        tests_run++; if (idtask_out !== 8'd3 || addrtcb_out !== tcb_addr(8'd3) || ctx_cnt - c0 != 1) begin
            tests_failed++; $display("FAIL preempt_switch got id=%h addr=%h ctx=%0d want 03 %h 1", idtask_out, addrtcb_out, ctx_cnt - c0, tcb_addr(8'd3)); end
        cur_id = 3;
    endtask

    task automatic test_yield;
        int b0, c0;
        ready_in = 16'h0008;
        c0 = ctx_cnt;
        step(20);
        tests_run++; if (idtask_out !== 8'd3 || ctx_cnt != c0) begin
            tests_failed++; $display("FAIL yield_setup got id=%h ctx=%0d want 03 0", idtask_out, ctx_cnt - c0); end
        repeat (2) do_tick(8);
        yield_in = 1'b1;
        step(1);
        yield_in = 1'b0;
        b0 = busy_cnt;
        c0 = ctx_cnt;
        step(19);
        tests_run++; if (busy_cnt - b0 != 18) begin tests_failed++; $display("FAIL yield_busy got %0d want 18", busy_cnt - b0); end
        tests_run++; if (idtask_out !== 8'd3 || ctx_cnt != c0) begin
            tests_failed++; $display("FAIL yield_same got id=%h ctx=%0d want 03 0", idtask_out, ctx_cnt - c0); end
        b0 = busy_cnt;
        repeat (3) do_tick(8);
        tests_run++; if (busy_cnt - b0 != 0) begin tests_failed++; $display("FAIL yield_reload got %0d busy cycles want 0", busy_cnt - b0); end
        do_tick(25);
        tests_run++; if (busy_cnt - b0 != 18) begin tests_failed++; $display("FAIL yield_expire got %0d busy cycles want 18", busy_cnt - b0); end
    endtask

    task automatic test_random;
        logic [N-1:0]        r;
        logic [N*PRIO_W-1:0] p;
        logic                changed;
        int exp, b0, c0, want_busy;
        for (int it = 0; it < 25; it++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 4) == 0) r = '0;
            p = prio_in;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) p[i*PRIO_W +: PRIO_W] = 6'($urandom_range(0, 3));
            changed = (r != ready_in) || (p != prio_in);
            exp = changed ? model_pick(cur_id, r, p) : cur_id;
            want_busy = !changed ? 0 : (exp == 255 ? 17 : 18);
            b0 = busy_cnt;
            c0 = ctx_cnt;
            ready_in = r;
            prio_in = p;
            step(22);
            tests_run++; if (idtask_out !== 8'(exp) || addrtcb_out !== exp_addr(exp) || idle_out !== (exp == 255)) begin
                tests_failed++; $display("FAIL rand_pick it=%0d got id=%h addr=%h idle=%b want %h %h %b",
                                         it, idtask_out, addrtcb_out, idle_out, 8'(exp), exp_addr(exp), exp == 255); end
            tests_run++; if (ctx_cnt - c0 != ((exp != cur_id) ? 1 : 0) || busy_cnt - b0 != want_busy) begin
                tests_failed++; $display("FAIL rand_pulses it=%0d got ctx=%0d busy=%0d want %0d %0d",
                                         it, ctx_cnt - c0, busy_cnt - b0, (exp != cur_id) ? 1 : 0, want_busy); end
            cur_id = exp;
        end
    endtask

    task automatic test_back_to_back;
        int b0 = busy_cnt;
        ready_in = 16'h0120;
        prio_in = '0;
        set_prio(5, 1);
        set_prio(8, 7);
        step(5);
        ready_in = 16'h0020;
        step(45);
        tests_run++; if (busy_cnt - b0 != 36) begin tests_failed++; $display("FAIL b2b_busy got %0d want 36", busy_cnt - b0); end
        tests_run++; if (idtask_out !== 8'd5) begin tests_failed++; $display("FAIL b2b_final got %h want 05", idtask_out); end
        cur_id = 5;
    endtask

    task automatic test_reset_mid_scan;
        int b0, c0, exp;
        ready_in = 16'h00F0;
        prio_in = '0;
        for (int i = 4; i < 8; i++) set_prio(i, 3);
        step(22);
        yield_in = 1'b1;
        step(1);
        yield_in = 1'b0;
        step(6);
        areset = 1'b1;
        step(1);
        areset = 1'b0;
        tests_run++; if (idle_out !== 1'b1 || idtask_out !== 8'hFF || addrtcb_out !== 32'd0 || busy_out !== 1'b0 ||
                         ctx_switch_out !== 1'b0 || tcb_rd_id_out !== 8'd0) begin
            tests_failed++; $display("FAIL midscan_reset got idle=%b id=%h addr=%h busy=%b ctx=%b rdid=%h want 1 ff 0 0 0 00",
                                     idle_out, idtask_out, addrtcb_out, busy_out, ctx_switch_out, tcb_rd_id_out); end
        b0 = busy_cnt;
        c0 = ctx_cnt;
        step(40);
        tests_run++; if (busy_cnt != b0 || ctx_cnt != c0 || idle_out !== 1'b1) begin
            tests_failed++; $display("FAIL midscan_quiet got busy=%0d ctx=%0d idle=%b want 0 0 1", busy_cnt - b0, ctx_cnt - c0, idle_out); end
        exp = model_pick(255, ready_in, prio_in);
        yield_in = 1'b1;
        step(1);
        yield_in = 1'b0;
        step(19);
        tests_run++; if (idtask_out !== 8'(exp) || addrtcb_out !== exp_addr(exp)) begin
            tests_failed++; $display("FAIL midscan_retrigger got id=%h addr=%h want %h %h", idtask_out, addrtcb_out, 8'(exp), exp_addr(exp)); end
        cur_id = exp;
    endtask

    initial begin
        areset = 1'b1;
        tick_in = 1'b0;
        yield_in = 1'b0;
        ready_in = '0;
        prio_in = '0;
        test_reset;
        test_idle_ticks;
        test_single;
        test_round_robin;
        test_preempt;
        test_yield;
        test_random;
        test_back_to_back;
        test_reset_mid_scan;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
